oracle_event_arbiter: RTL and testbench

Merges the per-stage oracle events (decode, rename, issue, writeback, commit) into one globally time-ordered stream. The stream feeds the single monitor process that issues the DPI event calls, at most one event per cycle. Each event is timestamped with a free-running cycle counter when it is captured. Events are then emitted oldest-first; ties are broken by pipeline stage order, so the oracle always sees decode before rename before issue before writeback before commit for events captured in the same cycle.

---
 rtl/oracle_event_arbiter.sv | 148 ++++++++++++++
 tb/tb_oracle_event_arbiter.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oracle_event_arbiter.sv
// Merges per-stage oracle events (decode..commit) into one globally time-ordered stream.
// Each source owns a small FIFO of {capture timestamp, payload}; the oldest head wins, ties go to the lowest index.
module oracle_event_arbiter #(
    parameter int NSRC      = 5,
    parameter int DEPTH     = 4,
    parameter int TS_W      = 16,
    parameter int PAYLOAD_W = 192,
    localparam int SRC_W    = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NSRC-1:0]           ev_valid_i,
    output logic [NSRC-1:0]           ev_ready_o,
    input  logic [NSRC*PAYLOAD_W-1:0] ev_payload_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [SRC_W-1:0]          out_src_o,
    output logic [TS_W-1:0]           out_ts_o,
    output logic [PAYLOAD_W-1:0]      out_payload_o,
    output logic                      overflow_o,
    output logic [15:0]               drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = TS_W + PAYLOAD_W;

    logic [TS_W-1:0]      now_q, now_d;
    logic [ENT_W-1:0]     mem_q    [NSRC][DEPTH];
    logic [PTR_W:0]       wr_ptr_q [NSRC];
    logic [PTR_W:0]       wr_ptr_d [NSRC];
    logic [PTR_W:0]       rd_ptr_q [NSRC];
    logic [PTR_W:0]       rd_ptr_d [NSRC];
    logic                 overflow_q, overflow_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    logic [NSRC-1:0]      empty, full, push, pop, drop;
    logic [TS_W-1:0]      head_ts  [NSRC];
    logic [PAYLOAD_W-1:0] head_pl  [NSRC];

    logic                 win_found;
    logic [SRC_W-1:0]     win_idx;
    logic [TS_W-1:0]      win_ts;
    logic [PAYLOAD_W-1:0] win_pl;

    logic [15:0]          drop_num;
    logic [16:0]          drop_sum;

    // Modular age test: a is older than b when (a - b) wraps negative.
    function automatic logic is_older(input logic [TS_W-1:0] a, input logic [TS_W-1:0] b);
        logic [TS_W-1:0] diff;
        diff = a - b;
        return diff[TS_W-1];
    endfunction

    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            empty[s] = (wr_ptr_q[s] == rd_ptr_q[s]);
            full[s]  = (wr_ptr_q[s][PTR_W] != rd_ptr_q[s][PTR_W]) &&
                       (wr_ptr_q[s][PTR_W-1:0] == rd_ptr_q[s][PTR_W-1:0]);
            {head_ts[s], head_pl[s]} = mem_q[s][rd_ptr_q[s][PTR_W-1:0]];
        end
    end

    assign ev_ready_o = ~full & {NSRC{~rst_i}};
    assign push       = ev_valid_i & ev_ready_o;
    assign drop       = ev_valid_i & ~ev_ready_o & {NSRC{~rst_i}};

    // Ascending scan with a strict "older" test keeps the lowest index on timestamp ties.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_ts    = '0;
        win_pl    = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (!empty[s] && (!win_found || is_older(head_ts[s], win_ts))) begin
                win_found = 1'b1;
                win_idx   = SRC_W'(s);
                win_ts    = head_ts[s];
                win_pl    = head_pl[s];
            end
        end
    end

    assign out_valid_o = win_found && !rst_i;

    always_comb begin
        out_src_o     = '0;
        out_ts_o      = '0;
        out_payload_o = '0;
        if (out_valid_o) begin
            out_src_o     = win_idx;
            out_ts_o      = win_ts;
            out_payload_o = win_pl;
        end
    end

    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            pop[s] = out_valid_o && out_ready_i && (win_idx == SRC_W'(s));
        end
    end

    always_comb begin
        now_d    = now_q + TS_W'(1);
        drop_num = '0;
        for (int s = 0; s < NSRC; s++) begin
            wr_ptr_d[s] = wr_ptr_q[s] + (PTR_W+1)'(push[s]);
            rd_ptr_d[s] = rd_ptr_q[s] + (PTR_W+1)'(pop[s]);
            drop_num    = drop_num + 16'(drop[s]);
        end
        drop_sum   = {1'b0, drop_cnt_q} + {1'b0, drop_num};
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow_d = overflow_q | (|drop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            now_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            for (int s = 0; s < NSRC; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
            end
        end else begin
            now_q      <= now_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            for (int s = 0; s < NSRC; s++) begin
                wr_ptr_q[s] <= wr_ptr_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
            end
        end
    end

    // Storage is not reset; pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < NSRC; s++) begin
            if (push[s]) begin
                mem_q[s][wr_ptr_q[s][PTR_W-1:0]] <= {now_q, ev_payload_i[s*PAYLOAD_W +: PAYLOAD_W]};
            end
        end
    end

    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_oracle_event_arbiter.sv
// Testbench for oracle_event_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model that picks the oldest event by age.
module tb_oracle_event_arbiter;

    localparam int NSRC  = 5;
    localparam int DEPTH = 4;
    localparam int TS_W  = 16;
    localparam int PW    = 192;
    localparam int SRC_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NSRC-1:0]      evValid;
    logic [NSRC-1:0]      evReady;
    logic [NSRC*PW-1:0]   evPayload;
    logic                 outValid;
    logic                 outReady;
    logic [SRC_W-1:0]     outSrc;
    logic [TS_W-1:0]      outTs;
    logic [PW-1:0]        outPayload;
    logic                 overflow;
    logic [15:0]          dropCnt;

    int checkCount = 0;
    int failCount  = 0;

    logic [TS_W-1:0] qTs [NSRC][$];
    logic [PW-1:0]   qPl [NSRC][$];
    int              modelNow      = 0;
    int              modelDrops    = 0;
    bit              modelOverflow = 1'b0;

    oracle_event_arbiter #(
        .NSRC(NSRC), .DEPTH(DEPTH), .TS_W(TS_W), .PAYLOAD_W(PW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ev_valid_i   (evValid),
        .ev_ready_o   (evReady),
        .ev_payload_i (evPayload),
        .out_valid_o  (outValid),
        .out_ready_i  (outReady),
        .out_src_o    (outSrc),
        .out_ts_o     (outTs),
        .out_payload_o(outPayload),
        .overflow_o   (overflow),
        .drop_cnt_o   (dropCnt)
    );

    function automatic logic [PW-1:0] randPayload();
        logic [PW-1:0] p;
        for (int i = 0; i < PW/32; i++) p[i*32 +: 32] = $urandom();
        return p;
    endfunction

    // Reference choice: the head that has waited longest (largest age), first index wins ties.
    function automatic int expWinner();
        int best;
        int bestAge;
        int age;
        best    = -1;
        bestAge = -1;
        for (int s = 0; s < NSRC; s++) begin
            if (qTs[s].size() > 0) begin
                age = (modelNow - int'(qTs[s][0]) + 65536) % 65536;
                if (age > bestAge) begin
                    bestAge = age;
                    best    = s;
                end
            end
        end
        return best;
    endfunction

    // Advance one clock edge, updating the model from the inputs held during the cycle.
    task automatic tick();
        int w;
        int nd;
        bit [NSRC-1:0] acc;
        w  = expWinner();
        nd = 0;
        if (rst) begin
            for (int s = 0; s < NSRC; s++) begin
                qTs[s].delete();
                qPl[s].delete();
            end
            modelNow      = 0;
            modelDrops    = 0;
            modelOverflow = 1'b0;
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                acc[s] = evValid[s] && (qTs[s].size() < DEPTH);
                if (evValid[s] && !acc[s]) nd++;
            end
            if (w >= 0 && outReady) begin
                qTs[w].delete(0);
                qPl[w].delete(0);
            end
            for (int s = 0; s < NSRC; s++) begin
                if (acc[s]) begin
                    qTs[s].push_back(16'(modelNow));
                    qPl[s].push_back(evPayload[s*PW +: PW]);
                end
            end
            modelDrops = (modelDrops + nd > 65535) ? 65535 : modelDrops + nd;
            if (nd > 0) modelOverflow = 1'b1;
            modelNow = (modelNow + 1) % 65536;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleTo(input int target);
        evValid = '0;
        while (modelNow != target) tick();
    endtask

    task automatic doReset();
        rst     = 1'b1;
        evValid = NSRC'($urandom());
        tick();
        rst     = 1'b0;
        evValid = '0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        evValid   = '1;
        evPayload = {randPayload(), randPayload(), randPayload(), randPayload(), randPayload()};
        outReady  = 1'b1;
        #1;
        checkCount++;
        if (evReady !== '0) begin failCount++; $display("[TB] FAIL reset.ready_during got %b want 00000", evReady); end
        tick();
        tick();
        #1;
        checkCount++;
        if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset.valid_during got %b want 0", outValid); end
        checkCount++;
        if (dropCnt !== 16'd0) begin failCount++; $display("[TB] FAIL reset.drop got %0d want 0", dropCnt); end
        checkCount++;
        if (overflow !== 1'b0) begin failCount++; $display("[TB] FAIL reset.overflow got %b want 0", overflow); end
        rst     = 1'b0;
        evValid = '0;
        #1;
        checkCount++;
        if (evReady !== '1) begin failCount++; $display("[TB] FAIL reset.ready_after got %b want 11111", evReady); end
        checkCount++;
        if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset.valid_after got %b want 0", outValid); end
    endtask

    task automatic test_single();
        logic [PW-1:0] pl;
        doReset();
        outReady = 1'b1;
        idleTo(5);
        pl        = randPayload();
        evPayload = '0;
        evPayload[0 +: PW] = pl;
        evValid   = 5'b00001;
        tick();
        evValid = '0;
        #1;
        checkCount++;
        if (outValid !== 1'b1 || outSrc !== 3'd0 || outTs !== 16'd5) begin
            failCount++;
            $display("[TB] FAIL single.head got v=%b src=%0d ts=%0d want v=1 src=0 ts=5", outValid, outSrc, outTs);
        end
        checkCount++;
        if (outPayload !== pl) begin failCount++; $display("[TB] FAIL single.payload got %h want %h", outPayload, pl); end
        tick();
        #1;
        checkCount++;
        if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL single.drained got %b want 0", outValid); end
    endtask

    task automatic test_tie();
        logic [PW-1:0] pl [NSRC];
        doReset();
        outReady = 1'b1;
        idleTo(10);
        for (int s = 0; s < NSRC; s++) begin
            pl[s] = randPayload();
            evPayload[s*PW +: PW] = pl[s];
        end
        evValid = '1;
        tick();
        evValid = '0;
        for (int i = 0; i < NSRC; i++) begin
            #1;
            checkCount++;
            if (outValid !== 1'b1 || outSrc !== SRC_W'(i) || outTs !== 16'd10 || outPayload !== pl[i]) begin
                failCount++;
                $display("[TB] FAIL tie.order[%0d] got v=%b src=%0d ts=%0d want v=1 src=%0d ts=10", i, outValid, outSrc, outTs, i);
            end
            tick();
        end
        #1;
        checkCount++;
        if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL tie.drained got %b want 0", outValid); end
    endtask

    task automatic test_age();
        int gotSrc [$];
        int gotTs  [$];
        doReset();
        outReady  = 1'b0;
        evPayload = {randPayload(), randPayload(), randPayload(), randPayload(), randPayload()};
        idleTo(3);
        evValid = 5'b10000;
        tick();
        idleTo(7);
        evValid = 5'b00001;
        tick();
        idleTo(9);
        outReady = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (outValid) begin
                gotSrc.push_back(int'(outSrc));
                gotTs.push_back(int'(outTs));
            end
            tick();
        end
        checkCount++;
        if (gotSrc.size() != 2) begin
            failCount++;
            $display("[TB] FAIL age.count got %0d want 2", gotSrc.size());
        end else begin
            checkCount++;
            if (gotSrc[0] != 4 || gotTs[0] != 3) begin failCount++; $display("[TB] FAIL age.first got src=%0d ts=%0d want src=4 ts=3", gotSrc[0], gotTs[0]); end
            checkCount++;
            if (gotSrc[1] != 0 || gotTs[1] != 7) begin failCount++; $display("[TB] FAIL age.second got src=%0d ts=%0d want src=0 ts=7", gotSrc[1], gotTs[1]); end
        end
    endtask

    task automatic test_overflow();
        logic [PW-1:0] pl [6];
        int n;
        doReset();
        outReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pl[i] = randPayload();
            evPayload[2*PW +: PW] = pl[i];
            evValid = 5'b00100;
            #1;
            checkCount++;
            if (evReady[2] !== (i < DEPTH)) begin
                failCount++;
                $display("[TB] FAIL overflow.ready[%0d] got %b want %b", i, evReady[2], (i < DEPTH));
            end
            tick();
        end
        evValid = '0;
        #1;
        checkCount++;
        if (dropCnt !== 16'd2 || overflow !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL overflow.count got drop=%0d ovf=%b want drop=2 ovf=1", dropCnt, overflow);
        end
        outReady = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (outValid) begin
                checkCount++;
                if (n >= DEPTH || outSrc !== 3'd2 || outTs !== 16'(n) || outPayload !== pl[n]) begin
                    failCount++;
                    $display("[TB] FAIL overflow.drain[%0d] got src=%0d ts=%0d want src=2 ts=%0d", n, outSrc, outTs, n);
                end
                n++;
            end
            tick();
        end
        checkCount++;
        if (n != DEPTH) begin failCount++; $display("[TB] FAIL overflow.drain_count got %0d want %0d", n, DEPTH); end
    endtask

    task automatic test_wrap();
        int gotSrc [$];
        int gotTs  [$];
        doReset();
        outReady  = 1'b0;
        evPayload = {randPayload(), randPayload(), randPayload(), randPayload(), randPayload()};
        idleTo(16'hFFFE);
        evValid = 5'b00010;
        tick();
        idleTo(1);
        evValid = 5'b01000;
        tick();
        idleTo(3);
        outReady = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (outValid) begin
                gotSrc.push_back(int'(outSrc));
                gotTs.push_back(int'(outTs));
            end
            tick();
        end
        checkCount++;
        if (gotSrc.size() != 2) begin
            failCount++;
            $display("[TB] FAIL wrap.count got %0d want 2", gotSrc.size());
        end else begin
            checkCount++;
            if (gotSrc[0] != 1 || gotTs[0] != 16'hFFFE) begin failCount++; $display("[TB] FAIL wrap.first got src=%0d ts=%0h want src=1 ts=fffe", gotSrc[0], gotTs[0]); end
            checkCount++;
            if (gotSrc[1] != 3 || gotTs[1] != 1) begin failCount++; $display("[TB] FAIL wrap.second got src=%0d ts=%0h want src=3 ts=1", gotSrc[1], gotTs[1]); end
        end
    endtask

    task automatic test_midreset();
        doReset();
        outReady  = 1'b0;
        evPayload = {randPayload(), randPayload(), randPayload(), randPayload(), randPayload()};
        evValid   = 5'b10000;
        for (int i = 0; i < 5; i++) tick();
        evValid = '0;
        #1;
        checkCount++;
        if (outValid !== 1'b1 || dropCnt !== 16'd1) begin
            failCount++;
            $display("[TB] FAIL midreset.before got v=%b drop=%0d want v=1 drop=1", outValid, dropCnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkCount++;
        if (outValid !== 1'b0 || dropCnt !== 16'd0 || overflow !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midreset.after got v=%b drop=%0d ovf=%b want v=0 drop=0 ovf=0", outValid, dropCnt, overflow);
        end
        outReady = 1'b1;
        evValid  = 5'b00001;
        tick();
        evValid = '0;
        #1;
        checkCount++;
        if (outValid !== 1'b1 || outSrc !== 3'd0 || outTs !== 16'd0) begin
            failCount++;
            $display("[TB] FAIL midreset.now_zero got v=%b src=%0d ts=%0d want v=1 src=0 ts=0", outValid, outSrc, outTs);
        end
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            checkCount++;
            if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL midreset.flushed[%0d] got v=%b src=%0d want v=0", c, outValid, outSrc); end
            tick();
        end
    endtask

    task automatic test_random();
        int w;
        bit expValid;
        logic [NSRC-1:0] expReady;
        doReset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int s = 0; s < NSRC; s++) begin
                evValid[s] = ($urandom_range(0, 99) < ((c < 1500) ? 15 : 40));
                evPayload[s*PW +: PW] = randPayload();
            end
            outReady = ($urandom_range(0, 3) != 0);
            #1;
            w = expWinner();
            expValid = !rst && (w >= 0);
            for (int s = 0; s < NSRC; s++) expReady[s] = !rst && (qTs[s].size() < DEPTH);
            checkCount++;
            if (outValid !== expValid) begin
                failCount++;
                $display("[TB] FAIL random.valid c=%0d got %b want %b", c, outValid, expValid);
            end else if (expValid) begin
                checkCount++;
                if (outSrc !== SRC_W'(w) || outTs !== qTs[w][0] || outPayload !== qPl[w][0]) begin
                    failCount++;
                    $display("[TB] FAIL random.head c=%0d got src=%0d ts=%0d want src=%0d ts=%0d", c, outSrc, outTs, w, qTs[w][0]);
                end
            end else begin
                checkCount++;
                if (outSrc !== '0 || outTs !== '0 || outPayload !== '0) begin
                    failCount++;
                    $display("[TB] FAIL random.idle_zero c=%0d got src=%0d ts=%0d want 0", c, outSrc, outTs);
                end
            end
            checkCount++;
            if (evReady !== expReady) begin failCount++; $display("[TB] FAIL random.ready c=%0d got %b want %b", c, evReady, expReady); end
            checkCount++;
            if (dropCnt !== 16'(modelDrops) || overflow !== modelOverflow) begin
                failCount++;
                $display("[TB] FAIL random.drops c=%0d got drop=%0d ovf=%b want drop=%0d ovf=%b", c, dropCnt, overflow, modelDrops, modelOverflow);
            end
            tick();
        end
        rst     = 1'b0;
        evValid = '0;
    endtask

    task automatic test_saturate();
        int c;
        doReset();
        outReady = 1'b0;
        evValid  = '1;
        c = 0;
        while (modelDrops < 65535 && c < 14000) begin
            if (c % 2000 == 1999) begin
                #1;
                checkCount++;
                if (dropCnt !== 16'(modelDrops)) begin failCount++; $display("[TB] FAIL saturate.progress c=%0d got %0d want %0d", c, dropCnt, modelDrops); end
            end
            tick();
            c++;
        end
        for (int i = 0; i < 5; i++) tick();
        evValid = '0;
        #1;
        checkCount++;
        if (dropCnt !== 16'hFFFF || modelDrops != 65535 || overflow !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL saturate.final got drop=%0h ovf=%b want drop=ffff ovf=1", dropCnt, overflow);
        end
    endtask

    initial begin
        rst       = 1'b1;
        evValid   = '0;
        evPayload = '0;
        outReady  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_tie();
        test_age();
        test_overflow();
        test_midreset();
        test_random();
        test_saturate();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
